// File: rtl/dds_cfg_pkg.sv
// Purpose: shared constants, wave codes and main-FSM state encoding for the DDS config controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dds_cfg_pkg;

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [7:0] ADDR_FREQ   = 8'h01;
  localparam logic [7:0] ADDR_AMP    = 8'h02;
  localparam logic [7:0] ADDR_WAVE   = 8'h03;
  localparam logic [7:0] ADDR_COMMIT = 8'h0F;

  localparam logic [2:0] WAVE_SIN = 3'b001;
  localparam logic [2:0] WAVE_TRI = 3'b010;
  localparam logic [2:0] WAVE_SQU = 3'b100;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_CSUM,
    ST_EXEC,
    ST_REPLY
  } state_e;

  // sin -> tri -> squ -> sin
  function automatic logic [2:0] wave_rotl(input logic [2:0] w);
    return {w[1:0], w[2]};
  endfunction

  // Only the three one-hot codes are accepted; the whole byte must match.
  function automatic logic wave_legal(input logic [7:0] v);
    return (v == 8'h01) || (v == 8'h02) || (v == 8'h04);
  endfunction

endpackage

// File: rtl/ft245_byte_if.sv
// Purpose: FT245 byte read/write strobe sequencer with bus drive enable.
// Latency: read 2*STROBE_CYC cycles after rxf low; write 2*STROBE_CYC+1 cycles after txe low.
// Backpressure: waits indefinitely on rxf/txe; one transfer at a time, read has priority.
module ft245_byte_if #(
  parameter int STROBE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxf,
  input  logic       txe,
  input  logic [7:0] d_in,
  input  logic       rd_req,
  output logic       rd_done,
  output logic [7:0] rd_data,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  output logic       wr_done,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       rd,
  output logic       wr
);

  typedef enum logic [2:0] {
    BI_IDLE,
    BI_RD_STB,
    BI_RD_GAP,
    BI_WR_STB,
    BI_WR_HOLD,
    BI_WR_GAP
  } bstate_e;

  localparam logic [3:0] LAST = 4'(STROBE_CYC - 1);

  bstate_e    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;

  // Done pulses fire in the last gap cycle so the requester advances on the same edge we go idle.
  assign rd_done = (state_q == BI_RD_GAP) && (cnt_q == LAST);
  assign wr_done = (state_q == BI_WR_GAP) && (cnt_q == LAST);
  assign rd_data = rdata_q;
  assign d_out   = dout_q;
  assign d_oe    = oe_q;
  assign rd      = rd_q;
  assign wr      = wr_q;

  // Strobe sequencing: every strobe and every gap lasts STROBE_CYC cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      BI_IDLE: begin
        cnt_d = '0;
        if (rd_req && !rxf) begin
          rd_d    = 1'b0;
          state_d = BI_RD_STB;
        end else if (wr_req && !txe) begin
          oe_d    = 1'b1;
          dout_d  = wr_data;
          wr_d    = 1'b1;
          state_d = BI_WR_STB;
        end
      end
      BI_RD_STB: begin
        if (cnt_q == LAST) begin
          rdata_d = d_in;   // last low cycle of the strobe
          rd_d    = 1'b1;
          cnt_d   = '0;
          state_d = BI_RD_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      BI_WR_STB: begin
        if (cnt_q == LAST) begin
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = BI_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      BI_WR_HOLD: begin
        oe_d    = 1'b0;   // keep data driven one cycle past the wr fall
        state_d = BI_WR_GAP;
      end
      BI_RD_GAP, BI_WR_GAP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = BI_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = BI_IDLE;
    endcase
  end

  // State and bus output registers; reset forces the bus idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BI_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: rtl/dds_cfg_ctrl.sv
// Purpose: framed host command decoder with shadow/active DDS registers, ACK/NAK replies and key merge.
// Latency: commit lands on the edge leaving EXEC; cfg_update high the following cycle.
// Backpressure: byte transfers stall on rxf/txe; in-frame gaps abort after TIMEOUT cycles.
module dds_cfg_ctrl
  import dds_cfg_pkg::*;
#(
  parameter int STROBE_CYC = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxf,
  input  logic        txe,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        rd,
  output logic        wr,
  input  logic        key_evt,
  output logic [15:0] freq_word,
  output logic [7:0]  amp,
  output logic [2:0]  wave_sel,
  output logic        cfg_update,
  output logic [7:0]  err_cnt
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d, csum_q, csum_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  reply_q, reply_d;
  logic [15:0] sh_freq_q, sh_freq_d, freq_q, freq_d;
  logic [7:0]  sh_amp_q, sh_amp_d, amp_q, amp_d;
  logic [2:0]  sh_wave_q, sh_wave_d, wave_q, wave_d;
  logic [7:0]  err_q, err_d;
  logic        cfg_upd_q, cfg_upd_d;

  logic        rd_req, rd_done, wr_req, wr_done;
  logic [7:0]  rd_data;
  logic        csum_ok, addr_ok, exec_ack, commit, key_fire;
  logic [7:0]  err_inc;

  ft245_byte_if #(.STROBE_CYC(STROBE_CYC)) u_bus (
    .clk(clk), .rst(rst), .rxf(rxf), .txe(txe), .d_in(d_in),
    .rd_req(rd_req), .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_data(reply_q), .wr_done(wr_done),
    .d_out(d_out), .d_oe(d_oe), .rd(rd), .wr(wr)
  );

  assign rd_req   = (state_q == ST_HUNT) || (state_q == ST_ADDR) || (state_q == ST_DHI) ||
                    (state_q == ST_DLO)  || (state_q == ST_CSUM);
  assign wr_req   = (state_q == ST_REPLY);
  assign csum_ok  = (csum_q == (addr_q ^ dhi_q ^ dlo_q));
  assign addr_ok  = (addr_q == ADDR_FREQ) || (addr_q == ADDR_AMP) || (addr_q == ADDR_COMMIT) ||
                    ((addr_q == ADDR_WAVE) && wave_legal(dlo_q));
  assign exec_ack = csum_ok && addr_ok;
  assign commit   = (state_q == ST_EXEC) && csum_ok && (addr_q == ADDR_COMMIT);
  assign key_fire = key_evt && !commit;   // commit wins a same-edge key press
  assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  assign freq_word  = freq_q;
  assign amp        = amp_q;
  assign wave_sel   = wave_q;
  assign cfg_update = cfg_upd_q;
  assign err_cnt    = err_q;

  // Frame parsing, byte-gap timeout, command execution and key rotation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dhi_d     = dhi_q;
    dlo_d     = dlo_q;
    csum_d    = csum_q;
    tmo_d     = tmo_q;
    reply_d   = reply_q;
    sh_freq_d = sh_freq_q;
    sh_amp_d  = sh_amp_q;
    sh_wave_d = sh_wave_q;
    freq_d    = freq_q;
    amp_d     = amp_q;
    wave_d    = wave_q;
    err_d     = err_q;
    cfg_upd_d = 1'b0;

    if (key_fire) begin
      wave_d    = wave_rotl(wave_q);
      sh_wave_d = wave_rotl(wave_q);
      cfg_upd_d = 1'b1;
    end
    if (commit) begin
      freq_d    = sh_freq_q;
      amp_d     = sh_amp_q;
      wave_d    = sh_wave_q;
      cfg_upd_d = 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        tmo_d = '0;
        if (rd_done && (rd_data == HDR)) state_d = ST_ADDR;
      end
      ST_ADDR, ST_DHI, ST_DLO, ST_CSUM: begin
        if (rd_done) begin
          tmo_d = '0;
          case (state_q)
            ST_ADDR: begin addr_d = rd_data; state_d = ST_DHI;  end
            ST_DHI:  begin dhi_d  = rd_data; state_d = ST_DLO;  end
            ST_DLO:  begin dlo_d  = rd_data; state_d = ST_CSUM; end
            default: begin csum_d = rd_data; state_d = ST_EXEC; end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          err_d   = err_inc;
          state_d = ST_HUNT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_EXEC: begin
        reply_d = exec_ack ? ACK : NAK;
        if (!exec_ack) err_d = err_inc;
        if (csum_ok && (addr_q == ADDR_FREQ)) sh_freq_d = {dhi_q, dlo_q};
        if (csum_ok && (addr_q == ADDR_AMP))  sh_amp_d  = dlo_q;
        if (csum_ok && (addr_q == ADDR_WAVE) && wave_legal(dlo_q)) sh_wave_d = dlo_q[2:0];
        state_d = ST_REPLY;
      end
      ST_REPLY: if (wr_done) state_d = ST_HUNT;
      default:  state_d = ST_HUNT;
    endcase
  end

  // All controller state; reset returns to power-on defaults with shadows matching actives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      addr_q    <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      csum_q    <= '0;
      tmo_q     <= '0;
      reply_q   <= '0;
      sh_freq_q <= 16'd1;
      sh_amp_q  <= 8'd1;
      sh_wave_q <= WAVE_SIN;
      freq_q    <= 16'd1;
      amp_q     <= 8'd1;
      wave_q    <= WAVE_SIN;
      err_q     <= '0;
      cfg_upd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dhi_q     <= dhi_d;
      dlo_q     <= dlo_d;
      csum_q    <= csum_d;
      tmo_q     <= tmo_d;
      reply_q   <= reply_d;
      sh_freq_q <= sh_freq_d;
      sh_amp_q  <= sh_amp_d;
      sh_wave_q <= sh_wave_d;
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      wave_q    <= wave_d;
      err_q     <= err_d;
      cfg_upd_q <= cfg_upd_d;
    end
  end

endmodule
